// File: rtl/reg_file_ckpt.sv
// Two-read / two-write pipeline register file with selectable write-to-read bypass
// and a single-level checkpoint/restore shadow bank for exception and mispredict recovery.
module reg_file_ckpt #(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 4,
    parameter int BYPASS   = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    output logic [DATA_WID-1:0] valA,
    output logic [DATA_WID-1:0] valB,
    input  logic [ADDR_WID-1:0] destE,
    input  logic [DATA_WID-1:0] valE,
    input  logic [ADDR_WID-1:0] destM,
    input  logic [DATA_WID-1:0] valM,
    input  logic                ckpt_save,
    input  logic                ckpt_restore,
    output logic                ckpt_valid,
    output logic                restore_err
);
    localparam int DEPTH = 2 ** ADDR_WID;
    localparam logic [ADDR_WID-1:0] NONE_REG = {ADDR_WID{1'b1}};

    logic [DATA_WID-1:0] r_regs   [DEPTH];
    logic [DATA_WID-1:0] r_shadow [DEPTH];
    logic [DATA_WID-1:0] w_next   [DEPTH];
    logic                r_ckpt_valid;
    logic                r_restore_err;
    logic                w_do_restore;
    logic                w_do_save;
    logic                w_byp_en;

    assign w_do_restore = ckpt_restore & r_ckpt_valid;
    assign w_do_save    = ckpt_save & ~w_do_restore;
    // Forwarding is meaningless while in reset or when this cycle's writes are thrown away.
    assign w_byp_en     = (BYPASS != 0) & RST_N & ~w_do_restore;

    assign ckpt_valid  = r_ckpt_valid;
    assign restore_err = r_restore_err;

    // Post-edge architectural state; M takes priority over E on the same address.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = r_regs[i];
            if (i == DEPTH - 1) begin
                w_next[i] = {DATA_WID{1'b0}};
            end else if (w_do_restore) begin
                w_next[i] = r_shadow[i];
            end else if (destM == ADDR_WID'(i)) begin
                w_next[i] = valM;
            end else if (destE == ADDR_WID'(i)) begin
                w_next[i] = valE;
            end else begin
                w_next[i] = r_regs[i];
            end
        end
    end

    // Architectural bank, shadow bank and checkpoint status.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i]   <= {DATA_WID{1'b0}};
                r_shadow[i] <= {DATA_WID{1'b0}};
            end
            r_ckpt_valid  <= 1'b0;
            r_restore_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= w_next[i];
                if (w_do_save) begin
                    r_shadow[i] <= w_next[i];
                end else begin
                    r_shadow[i] <= r_shadow[i];
                end
            end
            r_ckpt_valid  <= r_ckpt_valid | w_do_save;
            r_restore_err <= ckpt_restore & ~r_ckpt_valid;
        end
    end

    // Read port A.
    always_comb begin
        valA = r_regs[srcA];
        if (srcA == NONE_REG) begin
            valA = {DATA_WID{1'b0}};
        end else if (w_byp_en && (srcA == destM)) begin
            valA = valM;
        end else if (w_byp_en && (srcA == destE)) begin
            valA = valE;
        end else begin
            valA = r_regs[srcA];
        end
    end

    // Read port B.
    always_comb begin
        valB = r_regs[srcB];
        if (srcB == NONE_REG) begin
            valB = {DATA_WID{1'b0}};
        end else if (w_byp_en && (srcB == destM)) begin
            valB = valM;
        end else if (w_byp_en && (srcB == destE)) begin
            valB = valE;
        end else begin
            valB = r_regs[srcB];
        end
    end
endmodule

// File: tb/tb_reg_file_ckpt.sv
// Directed bench for reg_file_ckpt: a bypassing and a non-bypassing instance share stimulus.
module tb_reg_file_ckpt;
    logic        CLK;
    logic        RST_N;
    logic [3:0]  srcA, srcB, destE, destM;
    logic [31:0] valE, valM;
    logic        ckpt_save, ckpt_restore;
    logic [31:0] valA_b, valB_b, valA_n, valB_n;
    logic        cv_b, err_b, cv_n, err_n;
    int          n_cmp;
    int          n_fail;

    reg_file_ckpt #(.DATA_WID(32), .ADDR_WID(4), .BYPASS(1)) u_byp (
        .CLK(CLK), .RST_N(RST_N), .srcA(srcA), .srcB(srcB), .valA(valA_b), .valB(valB_b),
        .destE(destE), .valE(valE), .destM(destM), .valM(valM),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .ckpt_valid(cv_b), .restore_err(err_b)
    );

    reg_file_ckpt #(.DATA_WID(32), .ADDR_WID(4), .BYPASS(0)) u_nobyp (
        .CLK(CLK), .RST_N(RST_N), .srcA(srcA), .srcB(srcB), .valA(valA_n), .valB(valB_n),
        .destE(destE), .valE(valE), .destM(destM), .valM(valM),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
        .ckpt_valid(cv_n), .restore_err(err_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  sa, sb, de;
        logic [31:0] ve;
        logic [3:0]  dm;
        logic [31:0] vm;
        logic        sv, rs;
        logic [31:0] ea, eb, na, nb;
        logic        ev, ee;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] de, input logic [31:0] ve,
                         input logic [3:0] dm, input logic [31:0] vm,
                         input logic sv, input logic rs);
        srcA = sa; srcB = sb; destE = de; valE = ve; destM = dm; valM = vm;
        ckpt_save = sv; ckpt_restore = rs;
    endtask

    task automatic chk_reads(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic [31:0] na, input logic [31:0] nb);
        chk({tag, "_valA_byp"}, valA_b, ea);
        chk({tag, "_valB_byp"}, valB_b, eb);
        chk({tag, "_valA_nobyp"}, valA_n, na);
        chk({tag, "_valB_nobyp"}, valB_n, nb);
    endtask

    task automatic chk_status(input string tag, input logic ev, input logic ee);
        chk({tag, "_ckpt_valid_byp"}, {31'd0, cv_b}, {31'd0, ev});
        chk({tag, "_restore_err_byp"}, {31'd0, err_b}, {31'd0, ee});
        chk({tag, "_ckpt_valid_nobyp"}, {31'd0, cv_n}, {31'd0, ev});
        chk({tag, "_restore_err_nobyp"}, {31'd0, err_n}, {31'd0, ee});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //           sa     sb     de     ve        dm     vm        sv    rs    ea        eb        na        nb        ev    ee
        vecs[0]  = '{4'd3,  4'd14, 4'd15, 32'h0,    4'd15, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,    32'h0,    32'h0,    1'b0, 1'b0};
        vecs[1]  = '{4'd2,  4'd15, 4'd2,  32'h11,   4'd15, 32'h99,   1'b0, 1'b0, 32'h11,   32'h0,    32'h0,    32'h0,    1'b0, 1'b0};
        vecs[2]  = '{4'd2,  4'd15, 4'd15, 32'h0,    4'd15, 32'h0,    1'b0, 1'b0, 32'h11,   32'h0,    32'h11,   32'h0,    1'b0, 1'b0};
        vecs[3]  = '{4'd0,  4'd14, 4'd15, 32'h0,    4'd15, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,    32'h0,    32'h0,    1'b0, 1'b0};
        vecs[4]  = '{4'd5,  4'd5,  4'd5,  32'hAA,   4'd5,  32'hBB,   1'b0, 1'b0, 32'hBB,   32'hBB,   32'h0,    32'h0,    1'b0, 1'b0};
        vecs[5]  = '{4'd5,  4'd2,  4'd15, 32'h0,    4'd15, 32'h0,    1'b0, 1'b0, 32'hBB,   32'h11,   32'hBB,   32'h11,   1'b0, 1'b0};
        vecs[6]  = '{4'd7,  4'd3,  4'd7,  32'h77,   4'd3,  32'h33,   1'b0, 1'b0, 32'h77,   32'h33,   32'h0,    32'h0,    1'b0, 1'b0};
        vecs[7]  = '{4'd1,  4'd7,  4'd1,  32'h10,   4'd15, 32'h0,    1'b0, 1'b0, 32'h10,   32'h77,   32'h0,    32'h77,   1'b0, 1'b0};
        vecs[8]  = '{4'd1,  4'd0,  4'd1,  32'h20,   4'd15, 32'h0,    1'b1, 1'b0, 32'h20,   32'h0,    32'h10,   32'h0,    1'b1, 1'b0};
        vecs[9]  = '{4'd1,  4'd4,  4'd1,  32'h30,   4'd4,  32'h40,   1'b0, 1'b0, 32'h30,   32'h40,   32'h20,   32'h0,    1'b1, 1'b0};
        vecs[10] = '{4'd4,  4'd1,  4'd15, 32'h0,    4'd4,  32'h55,   1'b0, 1'b1, 32'h40,   32'h30,   32'h40,   32'h30,   1'b1, 1'b0};
        vecs[11] = '{4'd1,  4'd4,  4'd15, 32'h0,    4'd15, 32'h0,    1'b0, 1'b0, 32'h20,   32'h0,    32'h20,   32'h0,    1'b1, 1'b0};
        vecs[12] = '{4'd1,  4'd4,  4'd15, 32'h0,    4'd15, 32'h0,    1'b0, 1'b1, 32'h20,   32'h0,    32'h20,   32'h0,    1'b1, 1'b0};
        vecs[13] = '{4'd1,  4'd5,  4'd15, 32'h0,    4'd15, 32'h0,    1'b0, 1'b0, 32'h20,   32'hBB,   32'h20,   32'hBB,   1'b1, 1'b0};
        vecs[14] = '{4'd6,  4'd1,  4'd6,  32'h66,   4'd15, 32'h0,    1'b0, 1'b0, 32'h66,   32'h20,   32'h0,    32'h20,   1'b1, 1'b0};
        vecs[15] = '{4'd1,  4'd6,  4'd1,  32'hEE,   4'd15, 32'h0,    1'b1, 1'b1, 32'h20,   32'h66,   32'h20,   32'h66,   1'b1, 1'b0};
        vecs[16] = '{4'd6,  4'd1,  4'd15, 32'h0,    4'd15, 32'h0,    1'b0, 1'b0, 32'h0,    32'h20,   32'h0,    32'h20,   1'b1, 1'b0};

        // Power-on reset held for two edges, with a write presented to prove it is ignored.
        RST_N = 1'b0;
        drive(4'd3, 4'd14, 4'd3, 32'hDEAD, 4'd14, 32'hBEEF, 1'b1, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        chk_reads("in_reset", 32'h0, 32'h0, 32'h0, 32'h0);
        chk_status("in_reset", 1'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 17; i++) begin
            if (i > 0) @(negedge CLK);
            drive(vecs[i].sa, vecs[i].sb, vecs[i].de, vecs[i].ve,
                  vecs[i].dm, vecs[i].vm, vecs[i].sv, vecs[i].rs);
            #1;
            chk_reads($sformatf("v%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].na, vecs[i].nb);
            @(posedge CLK);
            #1;
            chk_status($sformatf("v%0d", i), vecs[i].ev, vecs[i].ee);
        end

        // Asynchronous reset between edges clears everything without a clock edge.
        @(negedge CLK);
        drive(4'd1, 4'd5, 4'd15, 32'h0, 4'd15, 32'h0, 1'b0, 1'b0);
        #1;
        chk_reads("pre_async", 32'h20, 32'hBB, 32'h20, 32'hBB);
        #1;
        RST_N = 1'b0;
        drive(4'd1, 4'd5, 4'd1, 32'h12, 4'd5, 32'h34, 1'b0, 1'b0);
        #1;
        chk_reads("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        chk_status("async_rst", 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        chk_reads("async_hold", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Restore with no snapshot: writes proceed, error pulses for one cycle.
        drive(4'd6, 4'd0, 4'd6, 32'h66, 4'd15, 32'h0, 1'b0, 1'b1);
        #1;
        chk_reads("norest", 32'h66, 32'h0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
        chk_status("norest", 1'b0, 1'b1);
        @(negedge CLK);
        drive(4'd6, 4'd0, 4'd15, 32'h0, 4'd15, 32'h0, 1'b0, 1'b0);
        #1;
        chk_reads("norest_after", 32'h66, 32'h0, 32'h66, 32'h0);
        @(posedge CLK);
        #1;
        chk_status("norest_after", 1'b0, 1'b0);

        // Save and restore together with no snapshot: save taken, error pulses.
        @(negedge CLK);
        drive(4'd8, 4'd6, 4'd8, 32'h88, 4'd15, 32'h0, 1'b1, 1'b1);
        #1;
        chk_reads("sv_rs", 32'h88, 32'h66, 32'h0, 32'h66);
        @(posedge CLK);
        #1;
        chk_status("sv_rs", 1'b1, 1'b1);
        @(negedge CLK);
        drive(4'd8, 4'd6, 4'd8, 32'h1, 4'd15, 32'h0, 1'b0, 1'b0);
        #1;
        chk_reads("sv_rs_wr", 32'h1, 32'h66, 32'h88, 32'h66);
        @(posedge CLK);
        #1;
        chk_status("sv_rs_wr", 1'b1, 1'b0);
        @(negedge CLK);
        drive(4'd8, 4'd6, 4'd15, 32'h0, 4'd15, 32'h0, 1'b0, 1'b1);
        #1;
        chk_reads("sv_rs_rest", 32'h1, 32'h66, 32'h1, 32'h66);
        @(posedge CLK);
        #1;
        chk_status("sv_rs_rest", 1'b1, 1'b0);
        @(negedge CLK);
        drive(4'd8, 4'd6, 4'd15, 32'h0, 4'd15, 32'h0, 1'b0, 1'b0);
        #1;
        chk_reads("sv_rs_final", 32'h88, 32'h66, 32'h88, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
